fifo_serial_tx: RTL and testbench
=================================

// Module: fifo_serial_tx
// PURPOSE
//  Consumer (read side) of the input-buffer FIFO. Drains `BUFF_SIZE-bit words from it
//  and shifts each word out on a single async-serial line (start, data LSB first,
//  optional parity, stop). Sits between the FIFO and the physical TX pin.
//  Provides pacing, framing and a frame counter for the link status logic.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range 2..65535
//  STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//  clk          in   1             system clock; all logic on posedge
//  rst          in   1             synchronous reset, active-high
//  tx_en        in   1             1 = allowed to start new frames
//  fifo_cnt     in   `BUFF_SIZE    FIFO word count (FIFO buf_cnt)
//  fifo_data    in   `BUFF_SIZE    FIFO read data; valid 1 cycle after fifo_rd_en
//  fifo_rd_en   out  1             FIFO read strobe, single-cycle pulse per word
//  tx           out  1             serial line; idle/stop = 1, start = 0
//  busy         out  1             1 in every state except IDLE
//  frame_done   out  1             1-cycle pulse in the last cycle of the final stop bit
//  frames_sent  out  16            frames transmitted since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0,
//   frames_sent=0, bit/clk counters=0. Applies mid-frame: the frame is abandoned,
//   tx returns to 1 the cycle after the reset edge, and no FIFO read is issued.
//  States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE  : tx=1. Goes to FETCH when tx_en=1 && fifo_cnt!=0. Otherwise holds.
//  FETCH : exactly 1 cycle. fifo_rd_en=1 (the only state in which it is 1).
//  LOAD  : exactly 1 cycle. shift_reg <= fifo_data. The FIFO's registered output is
//          valid here.
//  START : tx=0 for CLKS_PER_BIT cycles.
//  DATA  : `BUFF_SIZE bits, LSB first, each held CLKS_PER_BIT cycles.
//          Right-shift after each bit.
//  STOP  : tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//          Last cycle: frame_done=1 and frames_sent+1.
//  tx, busy and frame_done are registered and reflect the current state.
//  Latency: IDLE cycle that sees the condition = t0.
//   FETCH at t0+1, LOAD at t0+2, first tx=0 cycle at t0+3.
//  Back-to-back frames: the cycle after STOP is IDLE. This gives exactly
//   3 tx=1 cycles (IDLE, FETCH, LOAD) between frames when words remain.
//  fifo_cnt is sampled only in IDLE. The FIFO's count update after a read is
//   therefore never misread, and the block cannot issue two reads per word.
//  tx_en=0 mid-frame: the current frame completes unchanged. No new FETCH is issued.
//  fifo_cnt==0 in IDLE: no read is issued. The FIFO is never read when empty.
//  frames_sent wraps 16'hFFFF -> 16'h0000 with no flag.
//  Bit timer: a 16-bit down-counter reloaded with CLKS_PER_BIT-1 at each bit start.
// CONFIGURATION
//  FIFO_SERIAL_TX_PARITY_EN defined:
//   - PARITY state inserted after DATA.
//   - tx = ^shift_data_orig (even parity over the `BUFF_SIZE data bits),
//     held CLKS_PER_BIT cycles.
//  Not defined:
//   - PARITY state absent; DATA goes directly to STOP.
//  Frame length in bits = 1 + `BUFF_SIZE + P + STOP_BITS, where P = 1 with parity, 0 without.
// TESTING  (CLKS_PER_BIT=4, STOP_BITS=1, `BUFF_SIZE=8 unless stated)
//  1 Reset: rst=1 for 2 cycles, then 0.
//    -> tx=1, fifo_rd_en=0, busy=0, frame_done=0, frames_sent=0.
//  2 Single word 0xA5, fifo_cnt=1, tx_en=1:
//    -> one fifo_rd_en pulse.
//    -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
//    -> frame_done pulses once; frames_sent=1.
//  3 fifo_cnt=0, tx_en=1 for 200 cycles -> fifo_rd_en never 1, tx=1, busy=0.
//  4 Words 0x00, 0xFF, 0x3C queued, tx_en=1:
//    -> 3 rd pulses, 3 frames with exactly 3 idle-high cycles between them.
//    -> frames_sent=3.
//  5 tx_en->0 during DATA bit 3 with fifo_cnt=2:
//    -> the frame completes; no further fifo_rd_en; busy=0 afterwards.
//  6 rst pulse during DATA bit 5:
//    -> tx=1 next cycle; frames_sent=0; the next word is sent cleanly.
//    With FIFO_SERIAL_TX_PARITY_EN, send 0x07 -> parity bit = 1.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// Drains words from the input-buffer FIFO and shifts each one out as an async serial frame.
// Define FIFO_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
`timescale 1ns/1ps
`ifndef BUFF_SIZE
`define BUFF_SIZE 8
`endif

module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic [`BUFF_SIZE-1:0] fifo_cnt,
  input  logic [`BUFF_SIZE-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  LAST_DATA  = 8'(`BUFF_SIZE - 1);
  localparam logic [7:0]  LAST_STOP  = 8'(STOP_BITS - 1);

  state_t                  state_q;
  logic                    tx_q;
  logic                    rd_en_q;
  logic                    busy_q;
  logic                    frame_done_q;
  logic [15:0]             frames_q;
  logic [15:0]             clk_cnt_q;
  logic [7:0]              bit_cnt_q;
  logic [`BUFF_SIZE-1:0]   shift_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                    parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frames_q     <= 16'd0;
      clk_cnt_q    <= 16'd0;
      bit_cnt_q    <= 8'd0;
    end else begin
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        // fifo_cnt is only looked at here, so a stale count after a read is never seen
        S_IDLE: begin
          if (tx_en && fifo_cnt != '0) begin
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          shift_q   <= fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          parity_q  <= ^fifo_data;
`endif
          state_q   <= S_START;
          tx_q      <= 1'b0;
          clk_cnt_q <= BIT_RELOAD;
        end
        S_START: begin
          if (clk_cnt_q == 16'd0) begin
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= 8'd0;
            clk_cnt_q <= BIT_RELOAD;
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (clk_cnt_q == 16'd0) begin
            clk_cnt_q <= BIT_RELOAD;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= 8'd0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
              state_q   <= S_PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= S_STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
          end
        end
`ifdef FIFO_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt_q == 16'd0) begin
            state_q   <= S_STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= 8'd0;
            clk_cnt_q <= BIT_RELOAD;
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
          end
        end
`endif
        // frame_done and the counter are raised on entry to the final stop cycle
        S_STOP: begin
          if (clk_cnt_q == 16'd0) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
              clk_cnt_q <= BIT_RELOAD;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
            if (clk_cnt_q == 16'd1 && bit_cnt_q == LAST_STOP) begin
              frame_done_q <= 1'b1;
              frames_q     <= frames_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: queue-based FIFO model, line receiver and frame reference model.
`timescale 1ns/1ps
`ifndef BUFF_SIZE
`define BUFF_SIZE 8
`endif

module tb_fifo_serial_tx;
  localparam int CPB = 4;
  localparam int SB  = 1;
  localparam int W   = `BUFF_SIZE;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + W + P + SB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_en = 1'b0;
  logic [W-1:0] fifo_cnt = '0;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_rd_en, tx, busy, frame_done;
  logic [15:0]  frames_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_pulses = 0;
  int rd_cyc   = 0;
  int rd_empty = 0;
  int exp_frames = 0;
  logic [W-1:0] fq[$];

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_cnt(fifo_cnt), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data one cycle after the strobe, registered count
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en === 1'b1) begin
      rd_pulses++;
      rd_cyc = cyc;
      if (fq.size() == 0) rd_empty++;
      else fifo_data <= fq.pop_front();
    end
    fifo_cnt <= W'(fq.size());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, frames_sent=%0d", frames_sent);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] exp_frame(input logic [W-1:0] w);
    logic [NB-1:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < W; i++) b[1+i] = w[i];
    if (P == 1) b[1+W] = ^w;
    return b;
  endfunction

  // Receiver: waits for a start bit, then records each bit and frame_done placement
  task automatic capture(output logic [NB-1:0] bits, output int high_run, output int start_cyc,
                         output bit stable, output bit fd_ok, output bit tmo);
    bit last;
    bits = '0; high_run = 0; start_cyc = 0; stable = 1; fd_ok = 1; tmo = 0;
    while (tx !== 1'b0 && high_run < 1000) begin
      tick();
      high_run++;
    end
    if (high_run >= 1000) begin
      tmo = 1;
      return;
    end
    start_cyc = cyc;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) stable = 0;
        last = (b == NB - 1) && (c == CPB - 1);
        if (frame_done !== last) fd_ok = 0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", fifo_rd_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_checks++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
  endtask

  task automatic test_single();
    logic [NB-1:0] bits;
    int hr, sc, rd0;
    bit st, fd, tmo;
    rd0 = rd_pulses;
    fq.push_back(W'(8'hA5));
    tx_en = 1'b1;
    capture(bits, hr, sc, st, fd, tmo);
    tx_en = 1'b0;
    exp_frames++;
    n_checks++; if (tmo) begin n_fail++; $display("FAIL single_timeout: no start bit seen"); end
    n_checks++; if (bits !== exp_frame(W'(8'hA5))) begin n_fail++; $display("FAIL single_bits: got %b want %b", bits, exp_frame(W'(8'hA5))); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL single_bit_width: a bit changed within %0d cycles", CPB); end
    n_checks++; if (!fd) begin n_fail++; $display("FAIL single_frame_done: pulse not exactly on last stop cycle"); end
    n_checks++; if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL single_rd_pulses: got %0d want 1", rd_pulses - rd0); end
    n_checks++; if (sc - rd_cyc != 1) begin n_fail++; $display("FAIL single_latency: start %0d edges after read, want 1", sc - rd_cyc); end
    n_checks++; if (frames_sent !== 16'(exp_frames)) begin n_fail++; $display("FAIL single_frames: got %0d want %0d", frames_sent, exp_frames); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_empty();
    int rd0;
    rd0 = rd_pulses;
    tx_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      n_checks++;
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_idle: cycle %0d rd=%b tx=%b busy=%b want 0,1,0", i, fifo_rd_en, tx, busy);
      end
    end
    tx_en = 1'b0;
    n_checks++; if (rd_pulses != rd0) begin n_fail++; $display("FAIL empty_rd: got %0d reads want 0", rd_pulses - rd0); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3];
    logic [NB-1:0] bits;
    int hr, sc, rd0;
    bit st, fd, tmo;
    words[0] = W'(8'h00); words[1] = W'(8'hFF); words[2] = W'(8'h3C);
    rd0 = rd_pulses;
    for (int i = 0; i < 3; i++) fq.push_back(words[i]);
    tx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      capture(bits, hr, sc, st, fd, tmo);
      exp_frames++;
      n_checks++; if (tmo || bits !== exp_frame(words[i]) || !st || !fd) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %b want %b (tmo=%0d stable=%0d fd=%0d)", i, bits, exp_frame(words[i]), tmo, st, fd);
      end
      if (i > 0) begin
        n_checks++; if (hr != 3) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d idle-high cycles want 3", i, hr); end
      end
    end
    tx_en = 1'b0;
    n_checks++; if (rd_pulses - rd0 != 3) begin n_fail++; $display("FAIL b2b_rd_pulses: got %0d want 3", rd_pulses - rd0); end
    n_checks++; if (frames_sent !== 16'(exp_frames)) begin n_fail++; $display("FAIL b2b_frames: got %0d want %0d", frames_sent, exp_frames); end
    n_checks++; if (rd_empty != 0) begin n_fail++; $display("FAIL b2b_read_empty: got %0d want 0", rd_empty); end
  endtask

  task automatic test_random();
    logic [W-1:0] words[$];
    logic [NB-1:0] bits;
    int hr, sc;
    bit st, fd, tmo;
    for (int i = 0; i < 6; i++) begin
      words.push_back(W'($urandom_range(0, (1 << W) - 1)));
      fq.push_back(words[i]);
    end
    tx_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      capture(bits, hr, sc, st, fd, tmo);
      exp_frames++;
      n_checks++; if (tmo || bits !== exp_frame(words[i]) || !st || !fd || (i > 0 && hr != 3)) begin
        n_fail++; $display("FAIL random_frame%0d: got %b want %b (gap=%0d tmo=%0d stable=%0d fd=%0d)", i, bits, exp_frame(words[i]), hr, tmo, st, fd);
      end
    end
    tx_en = 1'b0;
    n_checks++; if (frames_sent !== 16'(exp_frames)) begin n_fail++; $display("FAIL random_frames: got %0d want %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_tx_en_off();
    int rd0, n;
    bit bad;
    rd0 = rd_pulses;
    fq.push_back(W'($urandom));
    fq.push_back(W'($urandom));
    tx_en = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 1000) begin tick(); n++; end
    repeat (CPB * 4 + 1) tick();
    tx_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
    exp_frames++;
    n_checks++; if (n >= 1000) begin n_fail++; $display("FAIL en_off_busy: busy still %b after 1000 cycles", busy); end
    n_checks++; if (frames_sent !== 16'(exp_frames)) begin n_fail++; $display("FAIL en_off_frames: got %0d want %0d", frames_sent, exp_frames); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL en_off_idle: activity seen after tx_en dropped, busy=%b tx=%b", busy, tx); end
    n_checks++; if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL en_off_rd_pulses: got %0d want 1", rd_pulses - rd0); end
    n_checks++; if (fq.size() != 1) begin n_fail++; $display("FAIL en_off_fifo_left: got %0d words want 1", fq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w1;
    logic [NB-1:0] bits;
    int hr, sc, n;
    bit st, fd, tmo;
    fq.delete();
    tick();
    tick();
    w1 = W'($urandom);
    fq.push_back(W'($urandom));
    fq.push_back(w1);
    tx_en = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 1000) begin tick(); n++; end
    repeat (CPB * 6 + 1) tick();
    rst = 1'b1;
    tick();
    exp_frames = 0;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx); end
    n_checks++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL midrst_frames: got %0d want 0", frames_sent); end
    n_checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: busy=%b rd=%b want 0,0", busy, fifo_rd_en); end
    rst = 1'b0;
    capture(bits, hr, sc, st, fd, tmo);
    tx_en = 1'b0;
    exp_frames++;
    n_checks++; if (tmo || bits !== exp_frame(w1) || !st || !fd) begin
      n_fail++; $display("FAIL midrst_next_frame: got %b want %b (tmo=%0d stable=%0d fd=%0d)", bits, exp_frame(w1), tmo, st, fd);
    end
    n_checks++; if (frames_sent !== 16'(exp_frames)) begin n_fail++; $display("FAIL midrst_frames_after: got %0d want %0d", frames_sent, exp_frames); end
  endtask

`ifdef FIFO_SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] bits;
    int hr, sc;
    bit st, fd, tmo;
    fq.push_back(W'(8'h07));
    tx_en = 1'b1;
    capture(bits, hr, sc, st, fd, tmo);
    tx_en = 1'b0;
    exp_frames++;
    n_checks++; if (tmo || bits[1+W] !== 1'b1) begin n_fail++; $display("FAIL parity_bit: got %b want 1", bits[1+W]); end
    n_checks++; if (bits !== exp_frame(W'(8'h07))) begin n_fail++; $display("FAIL parity_frame: got %b want %b", bits, exp_frame(W'(8'h07))); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_back_to_back();
    test_random();
    test_tx_en_off();
    test_reset_mid();
`ifdef FIFO_SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
